cache_ctrl_nway: RTL and testbench

Parametrised N-way set-associative, write-back, write-allocate cache controller sitting between the CPU request port and the memory controller. It generalises the single-way, fixed-geometry controller with configurable ways, sets and word width, true-LRU replacement, and a full-cache flush mode. Each line holds one DATA_W word. Tag, valid, dirty and age state are held in flops; the data array may be flops or inferred RAM, but reads must be combinational from the latched index.

---
 rtl/cache_ctrl_nway.sv | 276 +++++++++++++++++++++++++++
 tb/tb_cache_ctrl_nway.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_nway.sv
// rtl/cache_ctrl_nway.sv - N-way set-associative write-back/write-allocate cache controller
// True-LRU replacement and a full-cache flush walk; all outputs registered.
module cache_ctrl_nway #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WAYS   = 2,
  parameter int SETS   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_valid,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              mem_valid,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  input  logic              flush_req,
  output logic              flush_done
);
  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int AGE_W = WAY_W;

  typedef enum logic [2:0] {
    IDLE, COMPARE, WRITE_BACK, ALLOCATE, FLUSH_SCAN, FLUSH_WB
  } state_t;

  state_t state_q, state_d;

  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [DATA_W-1:0] data_q  [SETS][WAYS];
  logic [AGE_W-1:0]  age_q   [SETS][WAYS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];

  logic              req_rw_q;
  logic [TAG_W-1:0]  req_tag_q;
  logic [IDX_W-1:0]  req_idx_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic [WAY_W-1:0]  victim_q;
  logic [IDX_W-1:0]  fl_set_q;
  logic [WAY_W-1:0]  fl_way_q;

  logic [WAYS-1:0]  hit_vec;
  logic             hit;
  logic             any_inv;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] old_way;
  logic [WAY_W-1:0] victim_way;
  logic [AGE_W-1:0] hit_age;
  logic             fl_dirty;
  logic             fl_last;

  logic              cpu_ready_d, flush_done_d;
  logic [DATA_W-1:0] cpu_rdata_d, mem_wdata_d;
  logic              mem_valid_d, mem_rw_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic              latch_req, lru_upd, wr_hit, take_victim, fill;
  logic              fl_load, fl_clear, fl_wb_done;

  if (OFF_W > 0) begin : g_off
    logic unused_off;
    assign unused_off = ^cpu_addr[OFF_W-1:0];
  end

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                   input logic [IDX_W-1:0] idx);
    line_addr = ADDR_W'({tag, idx}) << OFF_W;
  endfunction

  // Descending scan so the lowest-index match/invalid way wins.
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    inv_way = '0;
    old_way = '0;
    any_inv = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit_vec[w] = valid_q[req_idx_q][w] && (tag_q[req_idx_q][w] == req_tag_q);
      if (valid_q[req_idx_q][w] && (tag_q[req_idx_q][w] == req_tag_q)) hit_way = WAY_W'(w);
      if (!valid_q[req_idx_q][w]) begin
        inv_way = WAY_W'(w);
        any_inv = 1'b1;
      end
      if (age_q[req_idx_q][w] == AGE_W'(WAYS - 1)) old_way = WAY_W'(w);
    end
    hit        = |hit_vec;
    hit_age    = age_q[req_idx_q][hit_way];
    victim_way = any_inv ? inv_way : old_way;
  end

  assign fl_dirty = valid_q[fl_set_q][fl_way_q] && dirty_q[fl_set_q][fl_way_q];
  assign fl_last  = (fl_set_q == IDX_W'(SETS - 1)) && (fl_way_q == WAY_W'(WAYS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    cpu_ready_d  = 1'b0;
    cpu_rdata_d  = cpu_rdata;
    flush_done_d = 1'b0;
    mem_valid_d  = mem_valid;
    mem_rw_d     = mem_rw;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    latch_req    = 1'b0;
    lru_upd      = 1'b0;
    wr_hit       = 1'b0;
    take_victim  = 1'b0;
    fill         = 1'b0;
    fl_load      = 1'b0;
    fl_clear     = 1'b0;
    fl_wb_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_req && !flush_done) begin
          state_d = FLUSH_SCAN;
        end else if (cpu_valid && !cpu_ready && !flush_done) begin
          latch_req = 1'b1;
          state_d   = COMPARE;
        end
      end
      COMPARE: begin
        if (hit) begin
          cpu_ready_d = 1'b1;
          lru_upd     = 1'b1;
          wr_hit      = req_rw_q;
          if (!req_rw_q) cpu_rdata_d = data_q[req_idx_q][hit_way];
          state_d = IDLE;
        end else begin
          take_victim = 1'b1;
          if (valid_q[req_idx_q][victim_way] && dirty_q[req_idx_q][victim_way])
            state_d = WRITE_BACK;
          else
            state_d = ALLOCATE;
        end
      end
      // The flush walk reuses this path: FLUSH_SCAN loads req_idx_q/victim_q.
      WRITE_BACK, FLUSH_WB: begin
        if (!mem_valid) begin
          mem_valid_d = 1'b1;
          mem_rw_d    = 1'b1;
          mem_addr_d  = line_addr(tag_q[req_idx_q][victim_q], req_idx_q);
          mem_wdata_d = data_q[req_idx_q][victim_q];
        end else if (mem_ready) begin
          mem_valid_d = 1'b0;
          if (state_q == WRITE_BACK) begin
            state_d = ALLOCATE;
          end else begin
            fl_wb_done = 1'b1;
            state_d    = FLUSH_SCAN;
          end
        end
      end
      ALLOCATE: begin
        if (!mem_valid) begin
          mem_valid_d = 1'b1;
          mem_rw_d    = 1'b0;
          mem_addr_d  = line_addr(req_tag_q, req_idx_q);
        end else if (mem_ready) begin
          mem_valid_d = 1'b0;
          fill        = 1'b1;
          state_d     = COMPARE;
        end
      end
      FLUSH_SCAN: begin
        if (fl_dirty) begin
          fl_load = 1'b1;
          state_d = FLUSH_WB;
        end else begin
          fl_clear = 1'b1;
          if (fl_last) begin
            flush_done_d = 1'b1;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_ready   <= 1'b0;
      cpu_rdata   <= '0;
      mem_valid   <= 1'b0;
      mem_rw      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      flush_done  <= 1'b0;
      req_rw_q    <= 1'b0;
      req_tag_q   <= '0;
      req_idx_q   <= '0;
      req_wdata_q <= '0;
      victim_q    <= '0;
      fl_set_q    <= '0;
      fl_way_q    <= '0;
    end else begin
      cpu_ready  <= cpu_ready_d;
      cpu_rdata  <= cpu_rdata_d;
      mem_valid  <= mem_valid_d;
      mem_rw     <= mem_rw_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      flush_done <= flush_done_d;
      if (latch_req) begin
        req_rw_q    <= cpu_rw;
        req_tag_q   <= cpu_addr[ADDR_W-1 -: TAG_W];
        req_idx_q   <= cpu_addr[OFF_W +: IDX_W];
        req_wdata_q <= cpu_wdata;
      end
      if (take_victim) victim_q <= victim_way;
      if (fl_load) begin
        req_idx_q <= fl_set_q;
        victim_q  <= fl_way_q;
      end
      if (fl_clear) begin
        if (fl_way_q == WAY_W'(WAYS - 1)) begin
          fl_way_q <= '0;
          fl_set_q <= fl_set_q + 1'b1;
        end else begin
          fl_way_q <= fl_way_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= AGE_W'(w);
      end
    end else begin
      if (lru_upd) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == hit_way)           age_q[req_idx_q][w] <= '0;
          else if (age_q[req_idx_q][w] < hit_age) age_q[req_idx_q][w] <= age_q[req_idx_q][w] + 1'b1;
        end
      end
      if (wr_hit) dirty_q[req_idx_q][hit_way] <= 1'b1;
      if (fill) begin
        valid_q[req_idx_q][victim_q] <= 1'b1;
        dirty_q[req_idx_q][victim_q] <= 1'b0;
      end
      if (fl_wb_done) dirty_q[req_idx_q][victim_q] <= 1'b0;
      if (fl_clear) begin
        valid_q[fl_set_q][fl_way_q] <= 1'b0;
        dirty_q[fl_set_q][fl_way_q] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[req_idx_q][victim_q] <= mem_rdata;
      tag_q[req_idx_q][victim_q]  <= req_tag_q;
    end else if (wr_hit) begin
      data_q[req_idx_q][hit_way] <= req_wdata_q;
    end
  end

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// tb/tb_cache_ctrl_nway.sv - directed self-checking bench for cache_ctrl_nway
// Instance 0 is the 2-way/64-set default; instance 1 is 4-way/4-set for LRU order.
module tb_cache_ctrl_nway;
  localparam int EXP_FLUSH = 64 * 2 + 1;

  logic        clk;
  logic        rst_n;
  logic        cpu_valid  [2];
  logic        cpu_rw     [2];
  logic [31:0] cpu_addr   [2];
  logic [31:0] cpu_wdata  [2];
  logic [31:0] cpu_rdata  [2];
  logic        cpu_ready  [2];
  logic        mem_valid  [2];
  logic        mem_rw     [2];
  logic [31:0] mem_addr   [2];
  logic [31:0] mem_wdata  [2];
  logic [31:0] mem_rdata  [2];
  logic        mem_ready  [2];
  logic        flush_req  [2];
  logic        flush_done [2];

  int checks = 0;
  int fails  = 0;
  int mem_lat = 3;
  logic [31:0] mem_model [longint];
  logic [31:0] wb_addr_q [$];
  logic [31:0] wb_data_q [$];

  cache_ctrl_nway u_dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_valid(cpu_valid[0]), .cpu_rw(cpu_rw[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
    .cpu_rdata(cpu_rdata[0]), .cpu_ready(cpu_ready[0]),
    .mem_valid(mem_valid[0]), .mem_rw(mem_rw[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .mem_ready(mem_ready[0]),
    .flush_req(flush_req[0]), .flush_done(flush_done[0])
  );

  cache_ctrl_nway #(.WAYS(4), .SETS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .cpu_valid(cpu_valid[1]), .cpu_rw(cpu_rw[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
    .cpu_rdata(cpu_rdata[1]), .cpu_ready(cpu_ready[1]),
    .mem_valid(mem_valid[1]), .mem_rw(mem_rw[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .mem_ready(mem_ready[1]),
    .flush_req(flush_req[1]), .flush_done(flush_done[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic longint mem_key(input int d, input logic [31:0] a);
    return (longint'(d) << 32) | longint'(a);
  endfunction

  function automatic logic [31:0] mem_read(input int d, input logic [31:0] a);
    if (mem_model.exists(mem_key(d, a))) return mem_model[mem_key(d, a)];
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory side: answers after mem_lat cycles of mem_valid, one-cycle mem_ready.
  task automatic mem_responder(input int d);
    int cnt = 0;
    mem_ready[d] = 1'b0;
    mem_rdata[d] = '0;
    forever begin
      @(negedge clk);
      if (mem_ready[d]) begin
        mem_ready[d] = 1'b0;
      end else if (mem_valid[d]) begin
        cnt++;
        if (cnt >= mem_lat) begin
          cnt = 0;
          mem_ready[d] = 1'b1;
          if (mem_rw[d]) begin
            mem_model[mem_key(d, mem_addr[d])] = mem_wdata[d];
            if (d == 0) begin
              wb_addr_q.push_back(mem_addr[d]);
              wb_data_q.push_back(mem_wdata[d]);
            end
          end else begin
            mem_rdata[d] = mem_read(d, mem_addr[d]);
          end
        end
      end else begin
        cnt = 0;
      end
    end
  endtask

  initial fork
    mem_responder(0);
    mem_responder(1);
  join_none

  task automatic cpu_access(input int d, input logic rw, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata,
                            output int lat, output int mreqs,
                            output logic [31:0] maddr0, output logic mrw0);
    logic prev_mv = 1'b0;
    @(negedge clk);
    cpu_valid[d] = 1'b1;
    cpu_rw[d]    = rw;
    cpu_addr[d]  = addr;
    cpu_wdata[d] = wdata;
    lat = 0; mreqs = 0; rdata = '0; maddr0 = '0; mrw0 = 1'b0;
    forever begin
      @(negedge clk);
      lat++;
      if (lat == 1) cpu_valid[d] = 1'b0;
      if (mem_valid[d] && !prev_mv) begin
        if (mreqs == 0) begin
          maddr0 = mem_addr[d];
          mrw0   = mem_rw[d];
        end
        mreqs++;
      end
      prev_mv = mem_valid[d];
      if (cpu_ready[d]) begin
        rdata = cpu_rdata[d];
        break;
      end
      if (lat >= 500) begin
        checks++; fails++;
        $display("FAIL cpu_access_timeout addr=%h cpu_ready=%0b required=1", addr, cpu_ready[d]);
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cpu_ready[0] !== 1'b0) begin fails++; $display("FAIL reset_cpu_ready got=%0b exp=0", cpu_ready[0]); end
    checks++; if (cpu_rdata[0] !== 32'h0) begin fails++; $display("FAIL reset_cpu_rdata got=%h exp=0", cpu_rdata[0]); end
    checks++; if (mem_valid[0] !== 1'b0) begin fails++; $display("FAIL reset_mem_valid got=%0b exp=0", mem_valid[0]); end
    checks++; if (mem_addr[0] !== 32'h0) begin fails++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr[0]); end
    checks++; if (mem_wdata[0] !== 32'h0) begin fails++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata[0]); end
    checks++; if (flush_done[0] !== 1'b0) begin fails++; $display("FAIL reset_flush_done got=%0b exp=0", flush_done[0]); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_miss_hit;
    logic [31:0] rd, a0;
    logic rw0;
    int lat, nr;
    mem_model[mem_key(0, 32'h40)] = 32'hDEAD_BEEF;
    cpu_access(0, 1'b0, 32'h40, 32'h0, rd, lat, nr, a0, rw0);
    checks++; if (nr !== 1) begin fails++; $display("FAIL miss_mem_reqs got=%0d exp=1", nr); end
    checks++; if (a0 !== 32'h40) begin fails++; $display("FAIL miss_mem_addr got=%h exp=00000040", a0); end
    checks++; if (rw0 !== 1'b0) begin fails++; $display("FAIL miss_mem_rw got=%0b exp=0", rw0); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL miss_rdata got=%h exp=deadbeef", rd); end
    cpu_access(0, 1'b0, 32'h40, 32'h0, rd, lat, nr, a0, rw0);
    checks++; if (lat !== 2) begin fails++; $display("FAIL hit_latency got=%0d exp=2", lat); end
    checks++; if (nr !== 0) begin fails++; $display("FAIL hit_mem_reqs got=%0d exp=0", nr); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL hit_rdata got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_evict_writeback;
    logic [31:0] rd, a0;
    logic rw0;
    int lat, nr;
    cpu_access(0, 1'b1, 32'h40, 32'h1111_1111, rd, lat, nr, a0, rw0);
    checks++; if (nr !== 0) begin fails++; $display("FAIL write_hit_mem_reqs got=%0d exp=0", nr); end
    wb_addr_q.delete();
    wb_data_q.delete();
    cpu_access(0, 1'b0, 32'h140, 32'h0, rd, lat, nr, a0, rw0);
    checks++; if (rd !== 32'hC0DE_0140) begin fails++; $display("FAIL evict_fill2_rdata got=%h exp=c0de0140", rd); end
    checks++; if (wb_addr_q.size() !== 0) begin fails++; $display("FAIL evict_early_wb got=%0d exp=0", wb_addr_q.size()); end
    cpu_access(0, 1'b0, 32'h240, 32'h0, rd, lat, nr, a0, rw0);
    checks++; if (nr !== 2) begin fails++; $display("FAIL evict_mem_reqs got=%0d exp=2", nr); end
    checks++; if (a0 !== 32'h40 || rw0 !== 1'b1) begin fails++; $display("FAIL evict_wb_req got=%h/%0b exp=00000040/1", a0, rw0); end
    checks++;
    if (wb_addr_q.size() != 1 || wb_data_q[0] !== 32'h1111_1111) begin
      fails++; $display("FAIL evict_wb_data count=%0d exp=1 data=%h exp=11111111", wb_addr_q.size(), (wb_data_q.size() > 0) ? wb_data_q[0] : 32'h0);
    end
    checks++; if (rd !== 32'hC0DE_0240) begin fails++; $display("FAIL evict_fill_rdata got=%h exp=c0de0240", rd); end
  endtask

  task automatic test_lru;
    logic [31:0] rd, a0;
    logic rw0;
    int lat, nr;
    for (int i = 0; i < 4; i++) cpu_access(1, 1'b0, 32'(i * 16), 32'h0, rd, lat, nr, a0, rw0);
    cpu_access(1, 1'b0, 32'h00, 32'h0, rd, lat, nr, a0, rw0);
    checks++; if (nr !== 0 || lat !== 2) begin fails++; $display("FAIL lru_hitA reqs=%0d lat=%0d exp=0/2", nr, lat); end
    cpu_access(1, 1'b0, 32'h40, 32'h0, rd, lat, nr, a0, rw0);
    checks++; if (nr !== 1 || a0 !== 32'h40) begin fails++; $display("FAIL lru_missE reqs=%0d addr=%h exp=1/00000040", nr, a0); end
    checks++; if (rd !== 32'hC0DE_0040) begin fails++; $display("FAIL lru_E_rdata got=%h exp=c0de0040", rd); end
    cpu_access(1, 1'b0, 32'h00, 32'h0, rd, lat, nr, a0, rw0);
    checks++; if (nr !== 0) begin fails++; $display("FAIL lru_A_resident reqs=%0d exp=0", nr); end
    checks++; if (rd !== 32'hC0DE_0000) begin fails++; $display("FAIL lru_A_rdata got=%h exp=c0de0000", rd); end
    cpu_access(1, 1'b0, 32'h10, 32'h0, rd, lat, nr, a0, rw0);
    checks++; if (nr !== 1) begin fails++; $display("FAIL lru_B_evicted reqs=%0d exp=1", nr); end
    cpu_access(1, 1'b0, 32'h30, 32'h0, rd, lat, nr, a0, rw0);
    checks++; if (nr !== 0) begin fails++; $display("FAIL lru_D_resident reqs=%0d exp=0", nr); end
  endtask

  task automatic test_flush;
    logic [31:0] rd, a0;
    logic rw0;
    int lat, nr, cnt, pulses;
    cpu_access(0, 1'b1, 32'h000, 32'hAAAA_0000, rd, lat, nr, a0, rw0);
    cpu_access(0, 1'b1, 32'h0FC, 32'hBBBB_00FC, rd, lat, nr, a0, rw0);
    wb_addr_q.delete();
    wb_data_q.delete();
    @(negedge clk);
    flush_req[0] = 1'b1;
    cnt = 0; pulses = 0;
    while (pulses == 0 && cnt < 3000) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) flush_req[0] = 1'b0;
      if (flush_done[0]) pulses++;
    end
    repeat (5) begin
      @(negedge clk);
      if (flush_done[0]) pulses++;
    end
    checks++; if (pulses !== 1) begin fails++; $display("FAIL flush_done_pulses got=%0d exp=1", pulses); end
    checks++; if (wb_addr_q.size() !== 2) begin fails++; $display("FAIL flush_wb_count got=%0d exp=2", wb_addr_q.size()); end
    if (wb_addr_q.size() == 2) begin
      checks++; if (wb_addr_q[0] !== 32'h000 || wb_data_q[0] !== 32'hAAAA_0000) begin fails++; $display("FAIL flush_wb0 got=%h/%h exp=00000000/aaaa0000", wb_addr_q[0], wb_data_q[0]); end
      checks++; if (wb_addr_q[1] !== 32'h0FC || wb_data_q[1] !== 32'hBBBB_00FC) begin fails++; $display("FAIL flush_wb1 got=%h/%h exp=000000fc/bbbb00fc", wb_addr_q[1], wb_data_q[1]); end
    end
    cpu_access(0, 1'b0, 32'h140, 32'h0, rd, lat, nr, a0, rw0);
    checks++; if (nr !== 1) begin fails++; $display("FAIL flush_clean_line_miss reqs=%0d exp=1", nr); end
    cpu_access(0, 1'b0, 32'h000, 32'h0, rd, lat, nr, a0, rw0);
    checks++; if (nr !== 1) begin fails++; $display("FAIL flush_dirty_line_miss reqs=%0d exp=1", nr); end
    checks++; if (rd !== 32'hAAAA_0000) begin fails++; $display("FAIL flush_refill_rdata got=%h exp=aaaa0000", rd); end
  endtask

  task automatic test_flush_and_cpu;
    int cnt, fd_at, rdy_at, nr, nr_flush;
    logic prev_mv;
    logic [31:0] rd;
    @(negedge clk);
    flush_req[0] = 1'b1;
    cpu_valid[0] = 1'b1;
    cpu_rw[0]    = 1'b0;
    cpu_addr[0]  = 32'h140;
    cnt = 0; fd_at = 0; rdy_at = 0; nr = 0; nr_flush = 0; prev_mv = 1'b0; rd = '0;
    while (rdy_at == 0 && cnt < 3000) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) flush_req[0] = 1'b0;
      if (flush_done[0]) fd_at = cnt;
      if (fd_at != 0 && cnt == fd_at + 2) cpu_valid[0] = 1'b0;
      if (mem_valid[0] && !prev_mv) begin
        if (fd_at == 0) nr_flush++;
        else nr++;
      end
      prev_mv = mem_valid[0];
      if (cpu_ready[0]) begin
        rdy_at = cnt;
        rd = cpu_rdata[0];
      end
    end
    cpu_valid[0] = 1'b0;
    checks++; if (fd_at !== EXP_FLUSH) begin fails++; $display("FAIL clean_flush_latency got=%0d exp=%0d", fd_at, EXP_FLUSH); end
    checks++; if (nr_flush !== 0) begin fails++; $display("FAIL clean_flush_mem_reqs got=%0d exp=0", nr_flush); end
    checks++; if (!(rdy_at > fd_at)) begin fails++; $display("FAIL cpu_after_flush ready_at=%0d flush_done_at=%0d", rdy_at, fd_at); end
    checks++; if (nr !== 1) begin fails++; $display("FAIL cpu_after_flush_reqs got=%0d exp=1", nr); end
    checks++; if (rd !== 32'hC0DE_0140) begin fails++; $display("FAIL cpu_after_flush_rdata got=%h exp=c0de0140", rd); end
  endtask

  task automatic test_reset_mid_alloc;
    logic [31:0] rd, a0;
    logic rw0;
    int lat, nr, cnt;
    mem_lat = 40;
    @(negedge clk);
    cpu_valid[0] = 1'b1;
    cpu_rw[0]    = 1'b0;
    cpu_addr[0]  = 32'h380;
    cnt = 0;
    while (!mem_valid[0] && cnt < 20) begin
      @(negedge clk);
      cnt++;
      cpu_valid[0] = 1'b0;
    end
    checks++; if (mem_valid[0] !== 1'b1) begin fails++; $display("FAIL alloc_started mem_valid=%0b exp=1", mem_valid[0]); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_valid[0] !== 1'b0) begin fails++; $display("FAIL async_reset_mem_valid got=%0b exp=0", mem_valid[0]); end
    checks++; if (mem_addr[0] !== 32'h0) begin fails++; $display("FAIL async_reset_mem_addr got=%h exp=0", mem_addr[0]); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mem_lat = 3;
    cpu_access(0, 1'b0, 32'h140, 32'h0, rd, lat, nr, a0, rw0);
    checks++; if (nr !== 1 || a0 !== 32'h140) begin fails++; $display("FAIL post_reset_miss reqs=%0d addr=%h exp=1/00000140", nr, a0); end
    checks++; if (rd !== 32'hC0DE_0140) begin fails++; $display("FAIL post_reset_rdata got=%h exp=c0de0140", rd); end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      cpu_valid[d] = 1'b0;
      cpu_rw[d]    = 1'b0;
      cpu_addr[d]  = '0;
      cpu_wdata[d] = '0;
      flush_req[d] = 1'b0;
    end
    rst_n = 1'b0;
    test_reset();
    test_read_miss_hit();
    test_evict_writeback();
    test_lru();
    test_flush();
    test_flush_and_cpu();
    test_reset_mid_alloc();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
